// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction queue between fetch and the dual-issue decoder
module inst_buffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int EXC_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       in_size,
  output logic             in_ready,
  input  logic [31:0]      in_pc1,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_pred_target1,
  input  logic             in_pred_taken1,
  input  logic [31:0]      in_pc2,
  input  logic [31:0]      in_inst2,
  input  logic [31:0]      in_pred_target2,
  input  logic             in_pred_taken2,
  input  logic             in_have_exception,
  input  logic [EXC_W-1:0] in_exception_type,
  input  logic [1:0]       deq_num,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic [31:0]      out_pc1,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_pred_target1,
  output logic             out_pred_taken1,
  output logic [31:0]      out_pc2,
  output logic [31:0]      out_inst2,
  output logic [31:0]      out_pred_target2,
  output logic             out_pred_taken2,
  output logic             out_exc1,
  output logic             out_exc2,
  output logic [EXC_W-1:0] out_exc_type1,
  output logic [EXC_W-1:0] out_exc_type2
);
  localparam int E_W = 98 + EXC_W;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [E_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0] count, free, sz, dq, wr_n, rd_n;
  logic exc_lock;
  logic [E_W-1:0] e1, e2;
  assign free = FULL - count;
  assign sz = (PTR_W+1)'(in_size == 2'd3 ? 2'd0 : in_size);
  assign dq = (PTR_W+1)'(deq_num == 2'd3 ? 2'd2 : deq_num);
  assign wr_n = (flush || exc_lock) ? '0 : (sz > free ? free : sz);
  assign rd_n = dq > count ? count : dq;
  assign in_ready = free >= (PTR_W+1)'(4);
  assign out_valid1 = count != '0;
  assign out_valid2 = count >= (PTR_W+1)'(2);
  assign e1 = {in_pc1, in_inst1, in_pred_target1, in_pred_taken1, in_have_exception, in_exception_type};
  assign e2 = {in_pc2, in_inst2, in_pred_target2, in_pred_taken2, 1'b0, EXC_W'(0)};
  assign {out_pc1, out_inst1, out_pred_target1, out_pred_taken1, out_exc1, out_exc_type1} = mem[head];
  assign {out_pc2, out_inst2, out_pred_target2, out_pred_taken2, out_exc2, out_exc_type2} = mem[head + PTR_W'(1)];
  // store accepted groups at the tail; group 2 lands one slot after group 1
  always_ff @(posedge clk) begin
    if (wr_n != '0) mem[tail] <= e1;
    if (wr_n >= (PTR_W+1)'(2)) mem[tail + PTR_W'(1)] <= e2;
  end
  // pointer, occupancy and exception-lock bookkeeping; reset and flush empty the queue
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      exc_lock <= 1'b0;
    end else begin
      head <= head + PTR_W'(rd_n);
      tail <= tail + PTR_W'(wr_n);
      count <= count + wr_n - rd_n;
      exc_lock <= exc_lock | (in_have_exception && wr_n != '0);
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: queue-model scoreboard bench for inst_buffer
module tb_inst_buffer;
  localparam int DEPTH = 8;
  localparam int EXC_W = 6;
  localparam logic [EXC_W-1:0] ADEF = 6'h08;
  typedef struct {
    logic [31:0] pc, inst, tgt;
    logic tk, exc;
    logic [EXC_W-1:0] et;
  } ent_t;
  logic clk = 0, reset = 1, flush = 0;
  logic [1:0] in_size = 0, deq_num = 0;
  logic in_ready;
  logic [31:0] in_pc1 = 0, in_inst1 = 0, in_pred_target1 = 0, in_pc2 = 0, in_inst2 = 0, in_pred_target2 = 0;
  logic in_pred_taken1 = 0, in_pred_taken2 = 0, in_have_exception = 0;
  logic [EXC_W-1:0] in_exception_type = 0;
  logic out_valid1, out_valid2, out_pred_taken1, out_pred_taken2, out_exc1, out_exc2;
  logic [31:0] out_pc1, out_inst1, out_pred_target1, out_pc2, out_inst2, out_pred_target2;
  logic [EXC_W-1:0] out_exc_type1, out_exc_type2;
  int compared = 0, mismatched = 0, violations = 0;
  bit started = 0, lock = 0;
  logic [31:0] pc_n = 0;
  ent_t q[$];

  inst_buffer #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_size(in_size), .in_ready(in_ready),
    .in_pc1(in_pc1), .in_inst1(in_inst1), .in_pred_target1(in_pred_target1), .in_pred_taken1(in_pred_taken1),
    .in_pc2(in_pc2), .in_inst2(in_inst2), .in_pred_target2(in_pred_target2), .in_pred_taken2(in_pred_taken2),
    .in_have_exception(in_have_exception), .in_exception_type(in_exception_type), .deq_num(deq_num),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_pc1(out_pc1), .out_inst1(out_inst1), .out_pred_target1(out_pred_target1), .out_pred_taken1(out_pred_taken1),
    .out_pc2(out_pc2), .out_inst2(out_inst2), .out_pred_target2(out_pred_target2), .out_pred_taken2(out_pred_taken2),
    .out_exc1(out_exc1), .out_exc2(out_exc2), .out_exc_type1(out_exc_type1), .out_exc_type2(out_exc_type2));

  always #5 clk = ~clk;

  function automatic logic [127:0] pack(ent_t e);
    return 128'({e.pc, e.inst, e.tgt, e.tk, e.exc, e.et});
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: mid-cycle, compare what the DUT presents with the model queue head
  always @(negedge clk) if (started) begin
    chk("in_ready", 128'(in_ready), 128'((DEPTH - q.size()) >= 4));
    chk("out_valid1", 128'(out_valid1), 128'(q.size() >= 1));
    chk("out_valid2", 128'(out_valid2), 128'(q.size() >= 2));
    if (q.size() >= 1)
      chk("port1", 128'({out_pc1, out_inst1, out_pred_target1, out_pred_taken1, out_exc1, out_exc_type1}), pack(q[0]));
    if (q.size() >= 2)
      chk("port2", 128'({out_pc2, out_inst2, out_pred_target2, out_pred_taken2, out_exc2, out_exc_type2}), pack(q[1]));
  end

  // behavioural queue model, advanced with the inputs the DUT sampled at this edge
  task automatic model_update();
    int sz, wr, rd;
    ent_t e;
    if (reset || flush) begin
      q.delete();
      lock = 0;
      return;
    end
    sz = (in_size == 3) ? 0 : int'(in_size);
    wr = lock ? 0 : ((sz < DEPTH - q.size()) ? sz : DEPTH - q.size());
    if (!lock && wr < sz) begin
      violations++;
      $display("note: write truncated, protocol violation (t=%0t)", $time);
    end
    rd = (deq_num == 3) ? 2 : int'(deq_num);
    if (rd > q.size()) rd = q.size();
    repeat (rd) void'(q.pop_front());
    if (wr >= 1) begin
      e = '{in_pc1, in_inst1, in_pred_target1, in_pred_taken1, in_have_exception, in_exception_type};
      q.push_back(e);
      if (in_have_exception) lock = 1;
    end
    if (wr >= 2) begin
      e = '{in_pc2, in_inst2, in_pred_target2, in_pred_taken2, 1'b0, '0};
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic put(int sz, int dq, bit fl = 0, bit exc = 0, logic [EXC_W-1:0] et = '0, bit adv = 1);
    in_size = 2'(sz);
    deq_num = 2'(dq);
    flush = fl;
    in_have_exception = exc;
    in_exception_type = et;
    in_pc1 = pc_n;
    in_pc2 = pc_n + 4;
    in_inst1 = $urandom;
    in_inst2 = $urandom;
    in_pred_target1 = $urandom;
    in_pred_target2 = $urandom;
    in_pred_taken1 = 1'($urandom);
    in_pred_taken2 = 1'($urandom);
    if (adv && sz < 3) pc_n = pc_n + 32'(4 * sz);
    step();
  endtask

  initial begin
    step();
    step();
    reset = 0;
    started = 1;
    pc_n = 32'h1c000000;
    put(2, 0);
    put(0, 0);
    repeat (2) put(2, 0);
    put(2, 0);
    put(2, 2);
    repeat (5) put(0, 2);
    for (int i = 0; i < 20; i++) put((i % 2) ? 2 : 1, 2);
    repeat (4) put(0, 2);
    pc_n = 32'h1c000002;
    repeat (5) put(1, 0, 0, 1, ADEF, 0);
    put(0, 0);
    put(0, 0, 1);
    pc_n = 32'h1c000100;
    put(1, 0);
    put(2, 0);
    put(2, 0);
    put(2, 2, 1);
    put(0, 0);
    put(1, 0);
    put(0, 2);
    put(2, 0);
    put(0, 3);
    put(3, 0);
    put(0, 0);
    for (int i = 0; i < 3000; i++) begin
      int sz, dq;
      bit exc;
      sz = in_ready ? int'($urandom_range(0, 3)) : 0;
      dq = int'($urandom_range(0, 3));
      exc = (sz == 1) && ($urandom_range(0, 29) == 0);
      put(sz, dq, $urandom_range(0, 39) == 0, exc, exc ? 6'($urandom) : '0);
    end
    put(0, 0);
    $display("protocol violations observed: %0d", violations);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Instruction buffer directly downstream of the fetch unit and upstream of the dual-issue decoder.
- Accepts 0, 1 or 2 fetched instruction groups per cycle. Each group carries pc, inst, predicted branch info and a fetch exception tag.
- Presents up to 2 oldest entries to decode each cycle, in program order.
- Flushed on any backend redirect (branch mispredict, exception, rewind).

Parameters:
- DEPTH, 8, number of entries. Power of 2, at least 4.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  OR of branch_mistaken, raise_exception and rewind, driven by the backend
- in_size  in  2  number of groups presented by fetch: 0, 1 or 2. The value 3 is illegal and is treated as 0.
- in_ready  out  1  fetch may launch a new request
- in_pc1, in_inst1, in_pred_target1  in  32 each  group 1 fields
- in_pred_taken1  in  1  group 1 predicted taken
- in_pc2, in_inst2, in_pred_target2  in  32 each  group 2 fields
- in_pred_taken2  in  1  group 2 predicted taken
- in_have_exception  in  1  fetch exception. Applies to group 1 only; valid only with in_size=1.
- in_exception_type  in  exception_t  fetch exception cause
- deq_num  in  2  entries consumed by decode this cycle (0..2)
- out_valid1, out_valid2  out  1 each  head entry and head+1 entry are valid
- out_pc1, out_inst1, out_pred_target1  out  32 each  head entry fields
- out_pred_taken1  out  1  head entry predicted taken
- out_pc2, out_inst2, out_pred_target2  out  32 each  head+1 entry fields
- out_pred_taken2  out  1  head+1 entry predicted taken
- out_exc1, out_exc2  out  1 each  entry carries a fetch exception
- out_exc_type1, out_exc_type2  out  exception_t  entry exception cause

Behaviour:
- Storage is a circular array of DEPTH entries. Each entry holds pc, inst, pred_taken, pred_target, exc, exc_type.
- Registered state: head, tail, count (PTR_W+1 bits), exc_lock.
- Reset: head=tail=count=0, exc_lock=0. Hence out_valid1=out_valid2=0 and in_ready=1. Entry data is don't-care.
- Outputs are combinational reads of registered state, with no write-to-read bypass:
  - out_valid1 = count>=1; out_valid2 = count>=2.
  - Port 1 reads storage[head]; port 2 reads storage[head+1 mod DEPTH].
- in_ready = (DEPTH-count) >= 4, computed from registered count.
  - Rationale: covers a write landing this cycle (up to 2) plus one outstanding fetch response (up to 2).
  - in_ready must not depend combinationally on in_size or deq_num.
- Accepted writes (wr_n):
  - If flush or exc_lock: wr_n=0.
  - Otherwise wr_n = min(in_size, DEPTH-count).
  - Truncation means a protocol violation; the bench flags it.
- Write placement:
  - Group 1 goes to storage[tail]; group 2 goes to storage[tail+1 mod DEPTH].
  - tail advances by wr_n, wrapping modulo DEPTH.
  - Group 1 takes exc/exc_type from in_have_exception/in_exception_type.
  - Group 2 always has exc=0.
- Exception lock:
  - Fetch re-presents the same exception entry every cycle. Therefore, when a group with in_have_exception=1 is accepted, exc_lock is set.
  - While exc_lock=1, all further input is ignored until flush.
- Reads:
  - rd_n = min(deq_num, count).
  - head advances by rd_n, wrapping modulo DEPTH.
- Count update: count_next = count + wr_n - rd_n. Simultaneous enqueue and dequeue are legal, including when count=DEPTH.
- Full boundary: when count=DEPTH and rd_n=2, wr_n is still 0, because wr_n uses the pre-dequeue count.
- Flush has highest priority. Next cycle: head=tail=count=0 and exc_lock=0. Writes and reads in the flush cycle are discarded.
- reset behaves like flush and also has priority over it.

Test Plan:
- Reset, then in_size=2 with pc 0x1c000000/0x1c000004, deq_num=0 -> next cycle out_valid1=out_valid2=1, out_pc1=0x1c000000, out_pc2=0x1c000004, count=2, in_ready=1.
- DEPTH=8, in_size=2 for 3 cycles, no dequeue -> count=6 and in_ready=0 in the cycle count becomes 6. A 4th size-2 write -> count=8. deq_num=2 with in_size=2 -> count=6 and the new entries are dropped (violation flagged).
- Wrap: alternate in_size=1 and in_size=2 with deq_num=2 for 20 cycles using an incrementing pc -> dequeued pcs strictly +4 sequential across the pointer wrap, with no loss or duplication.
- Exception: in_size=1, in_have_exception=1, ADEF, pc 0x1c000002, held 5 cycles -> exactly one entry, out_exc1=1, out_exc_type1=ADEF, count=1. Then flush -> count=0, exc_lock=0, and the next normal write is accepted.
- Flush with count=5, in_size=2, deq_num=2 in the same cycle -> next cycle count=0, out_valid1=0, in_ready=1.
- deq_num=2 with count=1 -> rd_n clamped to 1, count=0, head advanced by 1. deq_num=3 or in_size=3 -> treated as 2 and 0 respectively.
